// File: rtl/onehot_regfile.sv
// DEPTH x WIDTH register file with one-hot addressing, registered read/write-through,
// illegal-address flagging and a sequential checksum scan over all entries.
module onehot_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter logic [DEPTH*WIDTH-1:0] INIT = 64'hAA02_28FF_F00F_CC33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [DEPTH-1:0] address,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             addr_err,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic [WIDTH-1:0] checksum
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DEPTH-1:0] ADDR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  mem_reg [DEPTH];
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  sel_idx;
  logic              legal;
  logic              port_go;
  logic              last_idx;
  logic [DEPTH-1:0]  wr_en;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign legal    = (address != '0) && ((address & (address - ADDR_ONE)) == '0);
  assign port_go  = (state_reg == IDLE) && en && legal;
  assign last_idx = (idx_reg == IDX_W'(DEPTH - 1));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (address[DEPTH-1-i]) sel_idx = IDX_W'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = port_go && we && address[DEPTH-1-gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (scan_start) state_next = SCAN;
      SCAN:    if (last_idx) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= INIT[(DEPTH-1-i)*WIDTH +: WIDTH];
      data      <= '0;
      valid     <= 1'b0;
      addr_err  <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      checksum  <= '0;
      idx_reg   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= wdata;
      end

      data     <= '0;
      valid    <= 1'b0;
      addr_err <= 1'b0;
      if (state_reg == IDLE && en) begin
        if (legal) begin
          valid <= 1'b1;
          data  <= we ? wdata : mem_reg[sel_idx];
        end else begin
          addr_err <= 1'b1;
        end
      end

      // Scan reads one entry per cycle; port writes are blocked while it runs.
      case (state_reg)
        IDLE: if (scan_start) begin
          idx_reg   <= '0;
          checksum  <= '0;
          scan_busy <= 1'b1;
        end
        SCAN: begin
          checksum <= checksum + mem_reg[idx_reg];
          if (last_idx) begin
            scan_busy <= 1'b0;
            scan_done <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE:    scan_done <= 1'b0;
        default: scan_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_regfile.sv
// Randomized self-checking bench for onehot_regfile against a behavioural
// array model of the entries and arithmetic checksum.
module tb_onehot_regfile;
  localparam int W = 8;
  localparam int D = 8;
  localparam logic [D*W-1:0] INIT_V = 64'hAA02_28FF_F00F_CC33;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         we = 1'b0;
  logic [D-1:0] address = '0;
  logic [W-1:0] wdata = '0;
  logic         scan_start = 1'b0;
  logic [W-1:0] data;
  logic         valid;
  logic         addr_err;
  logic         scan_busy;
  logic         scan_done;
  logic [W-1:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_mem [D];

  onehot_regfile #(.WIDTH(W), .DEPTH(D), .INIT(INIT_V)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .address(address), .wdata(wdata),
    .data(data), .valid(valid), .addr_err(addr_err), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_done(scan_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D-1:0] addr_of(int i);
    logic [D-1:0] one;
    one = 1;
    return one << (D - 1 - i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) exp_mem[i] = INIT_V[(D-1-i)*W +: W];
  endtask

  function automatic logic [W-1:0] model_sum();
    int s = 0;
    for (int i = 0; i < D; i++) s = s + int'(exp_mem[i]);
    return W'(s);
  endfunction

  // Expected {data, valid, addr_err} for one idle-state access; updates the model on writes.
  task automatic model_access(input logic e, input logic w, input logic [D-1:0] a,
                              input logic [W-1:0] wd, output logic [W+1:0] exp_o);
    int sel = 0;
    if (!e) begin
      exp_o = '0;
    end else if ($countones(a) != 1) begin
      exp_o = {{W{1'b0}}, 1'b0, 1'b1};
    end else begin
      for (int i = 0; i < D; i++) if (a[D-1-i]) sel = i;
      if (w) begin
        exp_mem[sel] = wd;
        exp_o = {wd, 1'b1, 1'b0};
      end else begin
        exp_o = {exp_mem[sel], 1'b1, 1'b0};
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({data, valid, addr_err, scan_busy, scan_done, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_assert: data=%h valid=%b err=%b busy=%b done=%b csum=%h, required all zero",
               data, valid, addr_err, scan_busy, scan_done, checksum);
    end
    rst_n = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({data, valid, addr_err, checksum} !== '0) begin
        errors++;
        $display("FAIL reset_idle%0d: data=%h valid=%b err=%b csum=%h, required 00/0/0/00",
                 k, data, valid, addr_err, checksum);
      end
    end
  endtask

  task automatic test_read_all();
    logic [W+1:0] exp;
    for (int i = 0; i < D; i++) begin
      en = 1'b1; we = 1'b0; address = addr_of(i);
      model_access(en, we, address, wdata, exp);
      step();
      checks++;
      if ({data, valid, addr_err} !== exp) begin
        errors++;
        $display("FAIL read_entry%0d: data=%h valid=%b err=%b, required data=%h valid=%b err=%b",
                 i, data, valid, addr_err, exp[W+1:2], exp[1], exp[0]);
      end
      $display("read  addr=%h data=%h valid=%b", address, data, valid);
    end
    en = 1'b0;
  endtask

  task automatic test_write();
    logic [W+1:0] exp;
    logic [D-1:0] addrs [3];
    logic         wes [3];
    addrs[0] = 8'h10; wes[0] = 1'b1;
    addrs[1] = 8'h10; wes[1] = 1'b0;
    addrs[2] = 8'h08; wes[2] = 1'b0;
    wdata = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      en = 1'b1; we = wes[k]; address = addrs[k];
      model_access(en, we, address, wdata, exp);
      step();
      checks++;
      if ({data, valid, addr_err} !== exp) begin
        errors++;
        $display("FAIL write_seq%0d: data=%h valid=%b err=%b, required data=%h valid=%b err=%b",
                 k, data, valid, addr_err, exp[W+1:2], exp[1], exp[0]);
      end
      $display("wr/rd we=%b addr=%h data=%h valid=%b", we, address, data, valid);
    end
    en = 1'b0; we = 1'b0;
  endtask

  task automatic test_illegal();
    logic [W+1:0] exp;
    logic [D-1:0] addrs [3];
    logic         wes [3];
    addrs[0] = 8'h00; wes[0] = 1'b0;
    addrs[1] = 8'h81; wes[1] = 1'b1;
    addrs[2] = 8'h80; wes[2] = 1'b0;
    wdata = 8'h00;
    for (int k = 0; k < 3; k++) begin
      en = 1'b1; we = wes[k]; address = addrs[k];
      model_access(en, we, address, wdata, exp);
      step();
      checks++;
      if ({data, valid, addr_err} !== exp) begin
        errors++;
        $display("FAIL illegal_seq%0d: data=%h valid=%b err=%b, required data=%h valid=%b err=%b",
                 k, data, valid, addr_err, exp[W+1:2], exp[1], exp[0]);
      end
      $display("access addr=%h data=%h valid=%b addr_err=%b", address, data, valid, addr_err);
    end
    en = 1'b0; we = 1'b0;
    step();
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: addr_err=%b, required 0", addr_err);
    end
  endtask

  // Runs one full scan. With acc=1 a port access shares the scan_start edge;
  // with poke=1 writes are attempted throughout the scan and must be ignored.
  task automatic run_scan(input string tag, input logic acc, input logic poke);
    logic [W+1:0] exp;
    logic [W-1:0] exp_sum;
    scan_start = 1'b1;
    en = acc; we = 1'b1; address = addr_of($urandom_range(0, D - 1)); wdata = W'($urandom);
    model_access(en, we, address, wdata, exp);
    exp_sum = model_sum();
    for (int k = 0; k < D; k++) begin
      step();
      scan_start = 1'b0;
      if (k == 0) begin
        en = poke; we = 1'b1; address = 8'h80; wdata = W'($urandom);
      end else begin
        exp = '0;
      end
      checks++;
      if ({scan_busy, scan_done, data, valid, addr_err} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL %s_busy%0d: busy=%b done=%b data=%h valid=%b err=%b, required busy=1 done=0 data=%h valid=%b err=%b",
                 tag, k, scan_busy, scan_done, data, valid, addr_err, exp[W+1:2], exp[1], exp[0]);
      end
    end
    step();
    en = 1'b0; we = 1'b0;
    checks++;
    if ({scan_busy, scan_done, checksum, valid} !== {1'b0, 1'b1, exp_sum, 1'b0}) begin
      errors++;
      $display("FAIL %s_done: busy=%b done=%b csum=%h valid=%b, required busy=0 done=1 csum=%h valid=0",
               tag, scan_busy, scan_done, checksum, valid, exp_sum);
    end
    $display("scan %s checksum=%h done=%b", tag, checksum, scan_done);
    step();
    checks++;
    if ({scan_busy, scan_done, checksum} !== {1'b0, 1'b0, exp_sum}) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b csum=%h, required busy=0 done=0 csum=%h",
               tag, scan_busy, scan_done, checksum, exp_sum);
    end
  endtask

  task automatic test_scan_ignore();
    logic [W+1:0] exp;
    run_scan("poke", 1'b0, 1'b1);
    en = 1'b1; we = 1'b0; address = 8'h80;
    model_access(en, we, address, wdata, exp);
    step();
    en = 1'b0;
    checks++;
    if ({data, valid} !== exp[W+1:1]) begin
      errors++;
      $display("FAIL poke_entry0: data=%h valid=%b, required data=%h valid=1", data, valid, exp[W+1:2]);
    end
  endtask

  task automatic test_reset_midscan();
    logic [W+1:0] exp;
    en = 1'b1; we = 1'b1; address = 8'h10; wdata = 8'h5A;
    model_access(en, we, address, wdata, exp);
    step();
    en = 1'b0; we = 1'b0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({scan_busy, scan_done, checksum, data, valid} !== '0) begin
      errors++;
      $display("FAIL midscan_reset: busy=%b done=%b csum=%h data=%h valid=%b, required all zero",
               scan_busy, scan_done, checksum, data, valid);
    end
    step();
    rst_n = 1'b1;
    en = 1'b1; we = 1'b0; address = 8'h10;
    model_access(en, we, address, wdata, exp);
    step();
    en = 1'b0;
    checks++;
    if ({data, valid} !== exp[W+1:1]) begin
      errors++;
      $display("FAIL midscan_entry3: data=%h valid=%b, required data=%h valid=1", data, valid, exp[W+1:2]);
    end
    $display("after reset entry3=%h", data);
    run_scan("post_reset", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W+1:0] exp;
    for (int n = 0; n < 60; n++) begin
      en = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      address = ($urandom_range(0, 9) < 7) ? addr_of($urandom_range(0, D - 1)) : D'($urandom);
      wdata = W'($urandom);
      model_access(en, we, address, wdata, exp);
      step();
      checks++;
      if ({data, valid, addr_err} !== exp) begin
        errors++;
        $display("FAIL random%0d: data=%h valid=%b err=%b, required data=%h valid=%b err=%b",
                 n, data, valid, addr_err, exp[W+1:2], exp[1], exp[0]);
      end
      $display("rand en=%b we=%b addr=%h wdata=%h -> data=%h valid=%b err=%b",
               en, we, address, wdata, data, valid, addr_err);
    end
    en = 1'b0;
    run_scan("random", 1'b1, 1'b0);
    run_scan("random2", 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    run_scan("init", 1'b0, 1'b0);
    test_read_all();
    test_write();
    test_illegal();
    test_scan_ignore();
    test_reset_midscan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
